fir_interp: RTL and testbench

FIR_INTERP -- requirements
Module: fir_interp

---
 rtl/fir_interp_pkg.sv | 27 ++
 rtl/fir_interp_rom.sv | 26 ++
 rtl/fir_interp.sv | 163 ++++++++++++++++
 tb/tb_fir_interp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared defaults, phase-length derivation, test coefficient law and FSM states for fir_interp.
// The top-level saturation option is selected with FIR_INTERP_SAT_EN.
package fir_interp_pkg;

  localparam int IBITS_D = 18;
  localparam int OBITS_D = 18;
  localparam int RATIO_D = 8;
  localparam int TAPS_D  = 512;
  localparam int ABITS_D = 36;
  localparam int GBITS_D = 4;

  function automatic int ptaps_of(input int taps, input int ratio);
    return taps / ratio;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-positive prototype test response: h[k] = 2^(IBITS-3) + 8k
  function automatic int test_coef(input int k, input int ibits);
    return (1 << (ibits - 3)) + 8 * k;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FLUSH, ST_OUT} state_t;

endpackage

// File: rtl/fir_interp_rom.sv
// Polyphase coefficient ROM, phase-major addressing (p*PTAPS + j), one cycle read latency.
module fir_interp_rom
  import fir_interp_pkg::*;
#(
  parameter int IBITS = IBITS_D,
  parameter int RATIO = RATIO_D,
  parameter int TAPS  = TAPS_D,
  parameter int AW    = clog2_min1(TAPS)
) (
  input  logic                    clock,
  input  logic [AW-1:0]           addr,
  output logic signed [IBITS-1:0] coef
);

  localparam int PTAPS = ptaps_of(TAPS, RATIO);

  logic signed [IBITS-1:0] rom [TAPS];

  for (genvar a = 0; a < TAPS; a++) begin : g_rom
    // address a = p*PTAPS + j holds prototype tap h[j*RATIO + p]
    assign rom[a] = IBITS'(test_coef((a % PTAPS) * RATIO + a / PTAPS, IBITS));
  end

  always_ff @(posedge clock) coef <= rom[addr];

endmodule

// File: rtl/fir_interp.sv
// Polyphase complex interpolating FIR: one output per out_req, PTAPS-cycle shared-coefficient MAC.
// Define FIR_INTERP_SAT_EN to clamp overflowing outputs; otherwise they wrap.
module fir_interp
  import fir_interp_pkg::*;
#(
  parameter int IBITS = IBITS_D,
  parameter int OBITS = OBITS_D,
  parameter int RATIO = RATIO_D,
  parameter int TAPS  = TAPS_D,
  parameter int ABITS = ABITS_D,
  parameter int GBITS = GBITS_D
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    strobe_in,
  input  logic signed [IBITS-1:0] x_real,
  input  logic signed [IBITS-1:0] x_imag,
  input  logic                    out_req,
  output logic                    strobe_out,
  output logic signed [OBITS-1:0] y_real,
  output logic signed [OBITS-1:0] y_imag,
  output logic                    overrun
);

  localparam int PTAPS  = ptaps_of(TAPS, RATIO);
  localparam int JW     = clog2_min1(PTAPS);
  localparam int PW     = clog2_min1(RATIO);
  localparam int AW     = clog2_min1(TAPS);
  localparam int ACCW   = ABITS + GBITS;
  localparam int PRODW  = 2 * IBITS;
  localparam int STAGES = 1;

  localparam logic [JW:0]   FILL_MAX = (JW+1)'(PTAPS);
  localparam logic [JW-1:0] J_MAX    = JW'(PTAPS - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(RATIO - 1);

  state_t state, state_nx;

  logic [JW-1:0] wr_ptr, base, rd_ptr, j;
  logic [JW:0]   fill, fill_s;
  logic [PW-1:0] p, p_use, p_s;
  logic [AW-1:0] rom_addr;
  logic          accept, in_win;

  logic [STAGES:0]         vld_pipe;
  logic signed [IBITS-1:0] hist_r [2**JW];
  logic signed [IBITS-1:0] hist_i [2**JW];
  logic signed [IBITS-1:0] xr_q, xi_q, coef;
  logic signed [PRODW-1:0] prod_r, prod_i;
  logic signed [ACCW-1:0]  acc_r, acc_i;

  assign accept   = out_req && (state == ST_IDLE);
  assign p_use    = strobe_in ? '0 : p;
  // taps are walked oldest-first so a strobe_in during MAC only overwrites a slot already read
  assign rd_ptr   = base - j;
  assign in_win   = ({1'b0, j} < fill_s);
  assign rom_addr = AW'(int'(p_s) * PTAPS + int'(j));

  fir_interp_rom #(.IBITS(IBITS), .RATIO(RATIO), .TAPS(TAPS), .AW(AW)) u_rom (
    .clock (clock),
    .addr  (rom_addr),
    .coef  (coef)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (out_req) state_nx = ST_MAC;
      ST_MAC:   if (j == '0) state_nx = ST_FLUSH;
      ST_FLUSH: if (vld_pipe == '0) state_nx = ST_OUT;
      ST_OUT:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (strobe_in) begin
      hist_r[wr_ptr] <= x_real;
      hist_i[wr_ptr] <= x_imag;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      fill    <= '0;
      p       <= '0;
      base    <= '0;
      fill_s  <= '0;
      p_s     <= '0;
      j       <= '0;
      overrun <= 1'b0;
    end else begin
      if (strobe_in) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
      if (accept) begin
        p      <= (p_use == P_MAX) ? p_use : p_use + 1'b1;
        base   <= strobe_in ? wr_ptr : wr_ptr - 1'b1;
        fill_s <= (strobe_in && fill != FILL_MAX) ? fill + 1'b1 : fill;
        p_s    <= p_use;
        j      <= J_MAX;
      end else begin
        if (strobe_in) p <= '0;
        if (state == ST_MAC) j <= j - 1'b1;
      end
      if (out_req && state != ST_IDLE) overrun <= 1'b1;
    end
  end

  function automatic logic signed [OBITS-1:0] round_out(input logic signed [ACCW-1:0] a);
    logic signed [OBITS:0] s;
`ifdef FIR_INTERP_SAT_EN
    logic ovf;
`endif
    s = {a[ABITS-1], a[ABITS-1 -: OBITS]} + (OBITS+1)'(a[ABITS-1-OBITS]);
`ifdef FIR_INTERP_SAT_EN
    ovf = (a[ACCW-1:ABITS-1] != '0 && a[ACCW-1:ABITS-1] != '1) || (s[OBITS] != s[OBITS-1]);
    if (ovf) return a[ACCW-1] ? {1'b1, {(OBITS-1){1'b0}}} : {1'b0, {(OBITS-1){1'b1}}};
`endif
    return s[OBITS-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe   <= '0;
      xr_q       <= '0;
      xi_q       <= '0;
      prod_r     <= '0;
      prod_i     <= '0;
      acc_r      <= '0;
      acc_i      <= '0;
      strobe_out <= 1'b0;
      y_real     <= '0;
      y_imag     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == ST_MAC};
      xr_q     <= in_win ? hist_r[rd_ptr] : '0;
      xi_q     <= in_win ? hist_i[rd_ptr] : '0;
      prod_r   <= PRODW'(xr_q) * PRODW'(coef);
      prod_i   <= PRODW'(xi_q) * PRODW'(coef);
      if (accept) begin
        acc_r <= '0;
        acc_i <= '0;
      end else if (vld_pipe[STAGES]) begin
        acc_r <= acc_r + ACCW'(prod_r);
        acc_i <= acc_i + ACCW'(prod_i);
      end
      strobe_out <= (state == ST_OUT);
      if (state == ST_OUT) begin
        y_real <= round_out(acc_r);
        y_imag <= round_out(acc_i);
      end
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Scoreboard bench for fir_interp: driver queues expected outputs, monitor checks each strobe_out.
`timescale 1ns/1ps
module tb_fir_interp;

  localparam int IBITS = 18, OBITS = 18, RATIO = 8, TAPS = 64, ABITS = 36, GBITS = 4;
  localparam int PTAPS = TAPS / RATIO;
  localparam int LAT   = PTAPS + 4;

  logic clock = 1'b0, reset_n = 1'b0, strobe_in = 1'b0, out_req = 1'b0;
  logic signed [IBITS-1:0] x_real = '0, x_imag = '0;
  logic strobe_out, overrun;
  logic signed [OBITS-1:0] y_real, y_imag;

  typedef struct { longint yr; longint yi; int due; } exp_t;
  exp_t   exp_q[$];
  exp_t   mon_e;
  longint hr[$], hi[$];
  int     p_m = 0;
  int     cyc = 0;
  int     checks = 0, failures = 0;

  fir_interp #(.IBITS(IBITS), .OBITS(OBITS), .RATIO(RATIO), .TAPS(TAPS),
               .ABITS(ABITS), .GBITS(GBITS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe_in  (strobe_in),
    .x_real     (x_real),
    .x_imag     (x_imag),
    .out_req    (out_req),
    .strobe_out (strobe_out),
    .y_real     (y_real),
    .y_imag     (y_imag),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic longint coef(input int k);
    return (longint'(1) << (IBITS - 3)) + 8 * k;
  endfunction

  // accumulator -> output: round half-up at the first dropped bit, then clamp or wrap
  function automatic longint quant(input longint acc);
    longint v, lim;
    v   = (acc + (longint'(1) << (ABITS - OBITS - 1))) >>> (ABITS - OBITS);
    lim = longint'(1) << (OBITS - 1);
`ifdef FIR_INTERP_SAT_EN
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
`else
    v = v & ((lim << 1) - 1);
    if (v >= lim) v = v - (lim << 1);
`endif
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic void push_exp(input longint yr, input longint yi);
    exp_t e;
    e.yr = yr; e.yi = yi; e.due = cyc + 1 + LAT;
    exp_q.push_back(e);
    if (p_m < RATIO - 1) p_m++;
  endfunction

  function automatic void push_model();
    longint ar = 0, ai = 0;
    for (int jj = 0; jj < PTAPS; jj++)
      if (jj < hr.size()) begin
        ar += coef(jj * RATIO + p_m) * hr[hr.size() - 1 - jj];
        ai += coef(jj * RATIO + p_m) * hi[hi.size() - 1 - jj];
      end
    push_exp(quant(ar), quant(ai));
  endfunction

  task automatic strobe(input longint xr, input longint xi);
    strobe_in = 1'b1; x_real = IBITS'(xr); x_imag = IBITS'(xi);
    hr.push_back(xr); hi.push_back(xi); p_m = 0;
    tick(1);
    strobe_in = 1'b0;
  endtask

  // request with hand-supplied expectation, then let it finish
  task automatic req_hand(input longint yr, input longint yi);
    out_req = 1'b1; push_exp(yr, yi);
    tick(1); out_req = 1'b0;
    tick(LAT + 1);
  endtask

  task automatic req_model();
    out_req = 1'b1; push_model();
    tick(1); out_req = 1'b0;
    tick(LAT + 1);
  endtask

  always @(posedge clock) begin
    #1;
    if (reset_n && strobe_out) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe_out at cycle %0d y=(%0d,%0d)", cyc, y_real, y_imag);
      end else begin
        mon_e = exp_q.pop_front();
        check("y_real", longint'(y_real), mon_e.yr);
        check("y_imag", longint'(y_imag), mon_e.yi);
        check("strobe_latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    tick(3);
    check("reset_y_real", longint'(y_real), 0);
    check("reset_y_imag", longint'(y_imag), 0);
    check("reset_strobe_out", longint'(strobe_out), 0);
    check("reset_overrun", longint'(overrun), 0);
    reset_n = 1'b1;
    tick(2);

    // impulse: h*(2^17-1)/2^18 rounds half-up to exactly h/2 = 16384 + 4k
    for (int n = 0; n < PTAPS; n++) begin
      strobe(n == 0 ? 64'sh1FFFF : 0, 0);
      for (int r = 0; r < RATIO; r++) req_hand(16384 + 4 * (n * RATIO + r), 0);
    end

    // DC (+2^16, -2^16): y = S_p/4 with S_p = 263936 + 64p, i.e. +/-(65984 + 16p)
    for (int n = 0; n < PTAPS; n++) strobe(64'sh10000, -64'sh10000);
    for (int n = 0; n < 3; n++) begin
      strobe(64'sh10000, -64'sh10000);
      for (int r = 0; r < RATIO; r++) req_hand(65984 + 16 * r, -(65984 + 16 * r));
    end

    // second out_req 10 cycles into a MAC is dropped and flags overrun
    check("overrun_before", longint'(overrun), 0);
    strobe(64'sh10000, -64'sh10000);
    out_req = 1'b1; push_exp(65984, -65984);
    tick(1); out_req = 1'b0;
    tick(9);
    out_req = 1'b1;
    tick(1); out_req = 1'b0;
    check("overrun_set", longint'(overrun), 1);
    tick(LAT);
    check("overrun_sticky", longint'(overrun), 1);

    // simultaneous strobe_in/out_req uses the new sample at p=0; mid-MAC strobe ignored
    strobe_in = 1'b1; out_req = 1'b1; x_real = IBITS'(1000); x_imag = IBITS'(-2000);
    hr.push_back(1000); hi.push_back(-2000); p_m = 0;
    push_model();
    tick(1); strobe_in = 1'b0; out_req = 1'b0;
    tick(3);
    strobe(5000, 7000);
    tick(LAT);
    req_model();
    req_model();

    // reset mid-MAC: abandoned result, cleared outputs, zero history afterwards
    req_model();
    out_req = 1'b1; push_model();
    tick(1); out_req = 1'b0;
    tick(4);
    reset_n = 1'b0;
    exp_q.delete(); hr.delete(); hi.delete(); p_m = 0;
    tick(1);
    check("midreset_y_real", longint'(y_real), 0);
    check("midreset_y_imag", longint'(y_imag), 0);
    check("midreset_strobe_out", longint'(strobe_out), 0);
    check("midreset_overrun", longint'(overrun), 0);
    reset_n = 1'b1;
    tick(LAT + 4);
    check("postreset_y_real", longint'(y_real), 0);
    req_hand(0, 0);
    strobe(3000, -3000);
    req_model();

    // full scale with all-positive taps: clamps with saturation, wraps without
    for (int n = 0; n < PTAPS; n++) strobe(64'sh1FFFF, 64'sh1FFFF);
    for (int r = 0; r < RATIO; r++) req_model();

    tick(LAT + 4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
